// File: rtl/frame_ram_stream.sv
// frame_ram_stream
//   Simple-dual-port frame buffer. The write side takes a valid/ready pixel
//   stream into an auto-incrementing address pointer. It flags each completed
//   frame and can stop after one frame (WRAP=0) until it is re-armed. The read
//   side is a random-access request port with a registered output and
//   backpressure.
//
// Parameters
//   V        data width
//   S        depth in words
//   A        address width (S <= 2**A)
//   WRAP     1: pointer wraps and capture continues; 0: stop after S writes
//   RDW_MODE same-address same-cycle read/write: 0 old data, 1 new data
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o   write handshake, wr_data_i is the pixel word
//   wr_load_i/wr_addr_i     load the write pointer (ignored if wr_addr_i >= S)
//   wr_rearm_i              leave FULL and restart capture at address 0
//   wr_ptr_o                current write pointer
//   frame_done_o            one-cycle pulse after the word at S-1 is written
//   frame_cnt_o             completed-frame counter (modulo 256)
//   rd_req_i/rd_req_ready_o read request handshake, rd_addr_i is the address
//   rd_valid_o/rd_ready_i   read data handshake, rd_data_o is the word read

module frame_ram_stream #(
  parameter int V        = 8,
  parameter int S        = 76800,
  parameter int A        = 17,
  parameter int WRAP     = 1,
  parameter int RDW_MODE = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_valid_i,
  output logic         wr_ready_o,
  input  logic [V-1:0] wr_data_i,
  input  logic         wr_load_i,
  input  logic [A-1:0] wr_addr_i,
  input  logic         wr_rearm_i,
  output logic [A-1:0] wr_ptr_o,
  output logic         frame_done_o,
  output logic [7:0]   frame_cnt_o,
  input  logic         rd_req_i,
  output logic         rd_req_ready_o,
  input  logic [A-1:0] rd_addr_i,
  output logic         rd_valid_o,
  input  logic         rd_ready_i,
  output logic [V-1:0] rd_data_o
);

  localparam logic [A-1:0] LAST_ADDR = A'(S - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;

  wr_state_t    state_reg;
  logic [A-1:0] wr_ptr_reg;
  logic         frame_done_reg;
  logic [7:0]   frame_cnt_reg;
  logic         rd_valid_reg;
  logic [V-1:0] rd_data_reg;

  // Frame storage: contents are deliberately not reset.
  logic [V-1:0] mem [S];

  logic         load_ok;
  logic [A-1:0] wr_addr_eff;
  logic [A-1:0] ptr_next;
  logic         wr_fire;
  logic         rd_accept;
  logic         rd_oob;
  logic         rd_bypass;

  // An out-of-range load is dropped, so the write falls back to the pointer.
  assign load_ok     = wr_load_i && (32'(wr_addr_i) < 32'(S));
  assign wr_addr_eff = load_ok ? wr_addr_i : wr_ptr_reg;
  assign ptr_next    = (wr_addr_eff == LAST_ADDR) ? '0 : wr_addr_eff + A'(1);
  assign wr_fire     = wr_valid_i && (state_reg == FILL) && !rst_i;

  assign wr_ready_o     = (state_reg == FILL);
  assign rd_req_ready_o = !rd_valid_reg || rd_ready_i;
  assign rd_accept      = rd_req_i && rd_req_ready_o;
  assign rd_oob         = !(32'(rd_addr_i) < 32'(S));
  // New-data policy: forward the word being written this cycle to the reader.
  assign rd_bypass      = (RDW_MODE != 0) && wr_fire && (wr_addr_eff == rd_addr_i);

  // Write-side state machine, pointer and frame bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= FILL;
      wr_ptr_reg     <= '0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        FILL: begin
          if (wr_fire) begin
            wr_ptr_reg <= ptr_next;
            if (wr_addr_eff == LAST_ADDR) begin
              frame_done_reg <= 1'b1;
              frame_cnt_reg  <= frame_cnt_reg + 8'd1;
              if (WRAP == 0) begin
                state_reg <= FULL;
              end
            end
          end else if (load_ok) begin
            wr_ptr_reg <= wr_addr_i;
          end
        end
        FULL: begin
          if (wr_rearm_i) begin
            state_reg  <= FILL;
            wr_ptr_reg <= '0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[wr_addr_eff] <= wr_data_i;
    end
  end

  // Registered read port. The output holds while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else if (rd_accept) begin
      rd_valid_reg <= 1'b1;
      if (rd_oob) begin
        rd_data_reg <= '0;
      end else if (rd_bypass) begin
        rd_data_reg <= wr_data_i;
      end else begin
        rd_data_reg <= mem[rd_addr_i];
      end
    end else if (rd_ready_i) begin
      rd_valid_reg <= 1'b0;
    end
  end

  assign wr_ptr_o     = wr_ptr_reg;
  assign frame_done_o = frame_done_reg;
  assign frame_cnt_o  = frame_cnt_reg;
  assign rd_valid_o   = rd_valid_reg;
  assign rd_data_o    = rd_data_reg;

endmodule

// File: tb/tb_frame_ram_stream.sv
// Testbench for frame_ram_stream. It runs two instances side by side on
// shared stimulus. Instance 0 wraps and returns old data on a same-address
// read/write. Instance 1 is one-shot and returns new data in that case.
// A behavioural model built from arrays predicts each instance.

module tb_frame_ram_stream;

  localparam int FS = 76800;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_load;
  logic [16:0] wr_addr;
  logic        wr_rearm;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_ready;

  logic        wr_ready     [2];
  logic [16:0] wr_ptr       [2];
  logic        frame_done   [2];
  logic [7:0]  frame_cnt    [2];
  logic        rd_req_ready [2];
  logic        rd_valid     [2];
  logic [7:0]  rd_data      [2];

  int total = 0;
  int bad   = 0;

  // Reference model state, one slot per instance.
  logic [7:0] mem_m   [2][FS];
  bit         known_m [2][FS];
  int         ptr_m   [2];
  bit         full_m  [2];
  int         cnt_m   [2];
  bit         done_m  [2];
  bit         rv_m    [2];
  logic [7:0] rd_m    [2];
  bit         rdk_m   [2];

  always #5 clk = ~clk;

  frame_ram_stream #(.V(8), .S(FS), .A(17), .WRAP(1), .RDW_MODE(0)) dut_wrap (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready[0]), .wr_data_i(wr_data),
    .wr_load_i(wr_load), .wr_addr_i(wr_addr), .wr_rearm_i(wr_rearm),
    .wr_ptr_o(wr_ptr[0]), .frame_done_o(frame_done[0]), .frame_cnt_o(frame_cnt[0]),
    .rd_req_i(rd_req), .rd_req_ready_o(rd_req_ready[0]), .rd_addr_i(rd_addr),
    .rd_valid_o(rd_valid[0]), .rd_ready_i(rd_ready), .rd_data_o(rd_data[0])
  );

  frame_ram_stream #(.V(8), .S(FS), .A(17), .WRAP(0), .RDW_MODE(1)) dut_oneshot (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready[1]), .wr_data_i(wr_data),
    .wr_load_i(wr_load), .wr_addr_i(wr_addr), .wr_rearm_i(wr_rearm),
    .wr_ptr_o(wr_ptr[1]), .frame_done_o(frame_done[1]), .frame_cnt_o(frame_cnt[1]),
    .rd_req_i(rd_req), .rd_req_ready_o(rd_req_ready[1]), .rd_addr_i(rd_addr),
    .rd_valid_o(rd_valid[1]), .rd_ready_i(rd_ready), .rd_data_o(rd_data[1])
  );

  task automatic idle();
    rst = 1'b0; wr_valid = 1'b0; wr_load = 1'b0; wr_rearm = 1'b0;
    rd_req = 1'b0; rd_ready = 1'b1;
  endtask

  // Advance the model by one clock using the current inputs, then clock the
  // DUTs and return at the following falling edge.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      bit fire;
      int waddr;
      bit rdy;
      rdy = !rv_m[k] || rd_ready;
      if (rst) begin
        rv_m[k] = 0; rd_m[k] = 8'h00; rdk_m[k] = 1;
        ptr_m[k] = 0; full_m[k] = 0; cnt_m[k] = 0; done_m[k] = 0;
      end else begin
        waddr = (wr_load && wr_addr < FS) ? int'(wr_addr) : ptr_m[k];
        fire  = wr_valid && !full_m[k];
        done_m[k] = 0;
        if (rd_req && rdy) begin
          rv_m[k] = 1;
          if (rd_addr >= FS) begin
            rd_m[k] = 8'h00; rdk_m[k] = 1;
          end else if (k == 1 && fire && waddr == int'(rd_addr)) begin
            rd_m[k] = wr_data; rdk_m[k] = 1;
          end else begin
            rd_m[k] = mem_m[k][rd_addr]; rdk_m[k] = known_m[k][rd_addr];
          end
        end else if (rd_ready) begin
          rv_m[k] = 0;
        end
        if (full_m[k]) begin
          if (wr_rearm) begin
            full_m[k] = 0; ptr_m[k] = 0;
          end
        end else begin
          if (wr_load && wr_addr < FS) ptr_m[k] = int'(wr_addr);
          if (fire) begin
            mem_m[k][waddr] = wr_data; known_m[k][waddr] = 1;
            if (waddr == FS - 1) begin
              ptr_m[k] = 0; cnt_m[k] = (cnt_m[k] + 1) % 256; done_m[k] = 1;
              if (k == 1) full_m[k] = 1;
            end else begin
              ptr_m[k] = waddr + 1;
            end
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      total++; if (wr_ptr[k] !== 17'd0) begin bad++; $display("FAIL reset_ptr dut%0d: got %0d want 0", k, wr_ptr[k]); end
      total++; if (frame_cnt[k] !== 8'd0) begin bad++; $display("FAIL reset_cnt dut%0d: got %0d want 0", k, frame_cnt[k]); end
      total++; if (frame_done[k] !== 1'b0) begin bad++; $display("FAIL reset_done dut%0d: got %b want 0", k, frame_done[k]); end
      total++; if (rd_valid[k] !== 1'b0) begin bad++; $display("FAIL reset_rd_valid dut%0d: got %b want 0", k, rd_valid[k]); end
      total++; if (rd_data[k] !== 8'h00) begin bad++; $display("FAIL reset_rd_data dut%0d: got %h want 00", k, rd_data[k]); end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (wr_ready[k] !== 1'b1 || rd_req_ready[k] !== 1'b1) begin
        bad++; $display("FAIL reset_ready dut%0d: got wr=%b rd=%b want 1 1", k, wr_ready[k], rd_req_ready[k]);
      end
    end
    $display("reset checked");
  endtask

  task automatic test_frame_stream();
    int pulses [2];
    int pulse_at [2];
    logic [7:0] d;
    pulses = '{0, 0}; pulse_at = '{-1, -1};
    idle(); wr_valid = 1'b1;
    for (int i = 0; i < FS; i++) begin
      wr_data = i[7:0];
      step();
      for (int k = 0; k < 2; k++) if (frame_done[k] === 1'b1) begin pulses[k]++; pulse_at[k] = i; end
    end
    wr_valid = 1'b0;
    step();
    for (int k = 0; k < 2; k++) if (frame_done[k] === 1'b1) begin pulses[k]++; pulse_at[k] = FS; end
    for (int k = 0; k < 2; k++) begin
      total++; if (pulses[k] != 1 || pulse_at[k] != FS - 1) begin
        bad++; $display("FAIL frame_done_pulse dut%0d: got %0d pulses last at word %0d want 1 at %0d", k, pulses[k], pulse_at[k], FS - 1);
      end
      total++; if (frame_cnt[k] !== 8'd1) begin bad++; $display("FAIL frame_cnt dut%0d: got %0d want 1", k, frame_cnt[k]); end
      total++; if (wr_ptr[k] !== 17'd0) begin bad++; $display("FAIL frame_ptr dut%0d: got %0d want 0", k, wr_ptr[k]); end
    end
    total++; if (wr_ready[0] !== 1'b1 || wr_ready[1] !== 1'b0) begin
      bad++; $display("FAIL frame_wr_ready: got %b %b want 1 0", wr_ready[0], wr_ready[1]);
    end
    // The wrapping instance puts the next word at address 0.
    d = 8'($urandom_range(0, 255)); if (d == 8'h00) d = 8'h5A;
    wr_valid = 1'b1; wr_data = d;
    step();
    idle(); rd_req = 1'b1; rd_addr = 17'd0;
    step();
    rd_req = 1'b0;
    total++; if (rd_data[0] !== d || rd_valid[0] !== 1'b1) begin bad++; $display("FAIL wrap_next_word dut0: got %h want %h", rd_data[0], d); end
    total++; if (rd_data[1] !== 8'h00) begin bad++; $display("FAIL full_ignores_write dut1: got %h want 00", rd_data[1]); end
    total++; if (wr_ptr[0] !== 17'd1) begin bad++; $display("FAIL wrap_ptr dut0: got %0d want 1", wr_ptr[0]); end
    $display("frame stream checked: pulses %0d %0d", pulses[0], pulses[1]);
  endtask

  task automatic test_oneshot();
    logic [7:0] d;
    idle(); wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'($urandom_range(0, 255));
      #1;
      total++; if (wr_ready[1] !== 1'b0) begin bad++; $display("FAIL full_wr_ready dut1: got %b want 0", wr_ready[1]); end
      step();
    end
    wr_valid = 1'b0;
    total++; if (wr_ptr[1] !== 17'd0) begin bad++; $display("FAIL full_ptr dut1: got %0d want 0", wr_ptr[1]); end
    for (int a = 0; a < 3; a++) begin
      rd_req = 1'b1; rd_addr = 17'(a);
      step();
      total++; if (rd_data[1] !== 8'(a)) begin bad++; $display("FAIL full_ram_kept dut1 addr %0d: got %h want %h", a, rd_data[1], 8'(a)); end
      total++; if (rd_data[0] !== rd_m[0]) begin bad++; $display("FAIL wrap_read dut0 addr %0d: got %h want %h", a, rd_data[0], rd_m[0]); end
    end
    idle(); wr_rearm = 1'b1;
    step();
    wr_rearm = 1'b0;
    total++; if (wr_ready[1] !== 1'b1 || wr_ptr[1] !== 17'd0) begin
      bad++; $display("FAIL rearm dut1: got ready=%b ptr=%0d want 1 0", wr_ready[1], wr_ptr[1]);
    end
    d = 8'($urandom_range(0, 255)); if (d == 8'h00) d = 8'hC3;
    wr_valid = 1'b1; wr_data = d;
    step();
    idle(); rd_req = 1'b1; rd_addr = 17'd0;
    step();
    rd_req = 1'b0;
    total++; if (rd_data[1] !== d || wr_ptr[1] !== 17'd1) begin
      bad++; $display("FAIL rearm_write dut1: got data=%h ptr=%0d want %h 1", rd_data[1], wr_ptr[1], d);
    end
    $display("one-shot and re-arm checked");
  endtask

  task automatic test_rdw();
    idle(); wr_load = 1'b1; wr_addr = 17'd5; wr_valid = 1'b1; wr_data = 8'hAA;
    step();
    idle(); step(); step();
    wr_load = 1'b1; wr_addr = 17'd5; wr_valid = 1'b1; wr_data = 8'h55;
    rd_req = 1'b1; rd_addr = 17'd5;
    step();
    idle();
    total++; if (rd_data[0] !== 8'hAA) begin bad++; $display("FAIL rdw_old dut0: got %h want aa", rd_data[0]); end
    total++; if (rd_data[1] !== 8'h55) begin bad++; $display("FAIL rdw_new dut1: got %h want 55", rd_data[1]); end
    rd_req = 1'b1; rd_addr = 17'd5;
    step();
    rd_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (rd_data[k] !== 8'h55) begin bad++; $display("FAIL rdw_after dut%0d: got %h want 55", k, rd_data[k]); end
    end
    $display("read-during-write checked");
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    logic [7:0] got [2][$];
    int nxt;
    bit accepted;
    idle();
    for (int i = 0; i < 3; i++) begin
      w[i] = 8'($urandom_range(0, 255));
      wr_valid = 1'b1; wr_data = w[i]; wr_load = (i == 0); wr_addr = 17'd10;
      step();
    end
    idle(); step();
    nxt = 0;
    for (int c = 0; c < 8; c++) begin
      rd_ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      rd_req = (nxt < 3); rd_addr = 17'(10 + nxt);
      #1;
      for (int k = 0; k < 2; k++) if (rd_valid[k] === 1'b1 && rd_ready) got[k].push_back(rd_data[k]);
      if (c == 1 || c == 2) begin
        for (int k = 0; k < 2; k++) begin
          total++; if (rd_req_ready[k] !== 1'b0 || rd_valid[k] !== 1'b1 || rd_data[k] !== w[0]) begin
            bad++; $display("FAIL stall_hold dut%0d cycle %0d: got rdy=%b v=%b d=%h want 0 1 %h", k, c, rd_req_ready[k], rd_valid[k], rd_data[k], w[0]);
          end
        end
      end
      accepted = rd_req && (rd_req_ready[0] === 1'b1);
      step();
      if (accepted) nxt++;
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      total++; if (got[k].size() != 3) begin
        bad++; $display("FAIL b2b_count dut%0d: got %0d words want 3", k, got[k].size());
      end else begin
        for (int i = 0; i < 3; i++) begin
          total++; if (got[k][i] !== w[i]) begin bad++; $display("FAIL b2b_order dut%0d word %0d: got %h want %h", k, i, got[k][i], w[i]); end
        end
      end
    end
    $display("back-to-back reads checked");
  endtask

  task automatic test_load();
    logic [7:0] d;
    idle(); wr_load = 1'b1; wr_addr = 17'd100; wr_valid = 1'b1; wr_data = 8'h3C;
    step();
    for (int k = 0; k < 2; k++) begin
      total++; if (wr_ptr[k] !== 17'd101) begin bad++; $display("FAIL load_ptr dut%0d: got %0d want 101", k, wr_ptr[k]); end
    end
    idle(); wr_load = 1'b1; wr_addr = 17'd80000;
    step();
    for (int k = 0; k < 2; k++) begin
      total++; if (wr_ptr[k] !== 17'd101) begin bad++; $display("FAIL load_oob_ptr dut%0d: got %0d want 101", k, wr_ptr[k]); end
    end
    d = 8'($urandom_range(0, 255));
    wr_valid = 1'b1; wr_data = d;
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      total++; if (wr_ptr[k] !== 17'd102) begin bad++; $display("FAIL load_oob_write dut%0d: got %0d want 102", k, wr_ptr[k]); end
    end
    rd_req = 1'b1; rd_addr = 17'd101; step();
    for (int k = 0; k < 2; k++) begin
      total++; if (rd_data[k] !== d) begin bad++; $display("FAIL load_oob_data dut%0d: got %h want %h", k, rd_data[k], d); end
    end
    rd_addr = 17'd100; step();
    for (int k = 0; k < 2; k++) begin
      total++; if (rd_data[k] !== 8'h3C) begin bad++; $display("FAIL load_data dut%0d: got %h want 3c", k, rd_data[k]); end
    end
    rd_addr = 17'd80000; step();
    rd_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (rd_data[k] !== 8'h00 || rd_valid[k] !== 1'b1) begin
        bad++; $display("FAIL read_oob dut%0d: got v=%b d=%h want 1 00", k, rd_valid[k], rd_data[k]);
      end
    end
    $display("pointer load and out-of-range access checked");
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      rst      = 1'b0;
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom_range(0, 255));
      r        = $urandom_range(0, 15);
      wr_load  = (r < 3);
      wr_addr  = (r == 0) ? 17'(FS - 2) : (r == 1) ? 17'($urandom_range(0, 31)) : 17'(FS + $urandom_range(0, 100));
      wr_rearm = ($urandom_range(0, 7) == 0);
      rd_req   = 1'($urandom_range(0, 1));
      r        = $urandom_range(0, 9);
      rd_addr  = (r == 0) ? 17'(FS + 5) : (r == 1) ? 17'(FS - 1) : (r == 2) ? 17'(FS - 2) : 17'($urandom_range(0, 31));
      rd_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++; if (wr_ready[k] !== !full_m[k]) begin bad++; $display("FAIL rnd_wr_ready dut%0d cycle %0d: got %b want %b", k, c, wr_ready[k], !full_m[k]); end
        total++; if (rd_req_ready[k] !== (!rv_m[k] || rd_ready)) begin bad++; $display("FAIL rnd_rd_req_ready dut%0d cycle %0d: got %b want %b", k, c, rd_req_ready[k], (!rv_m[k] || rd_ready)); end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        total++; if (rd_valid[k] !== rv_m[k]) begin bad++; $display("FAIL rnd_rd_valid dut%0d cycle %0d: got %b want %b", k, c, rd_valid[k], rv_m[k]); end
        if (rv_m[k] && rdk_m[k]) begin
          total++; if (rd_data[k] !== rd_m[k]) begin bad++; $display("FAIL rnd_rd_data dut%0d cycle %0d: got %h want %h", k, c, rd_data[k], rd_m[k]); end
        end
        total++; if (wr_ptr[k] !== 17'(ptr_m[k])) begin bad++; $display("FAIL rnd_ptr dut%0d cycle %0d: got %0d want %0d", k, c, wr_ptr[k], ptr_m[k]); end
        total++; if (frame_cnt[k] !== 8'(cnt_m[k]) || frame_done[k] !== done_m[k]) begin
          bad++; $display("FAIL rnd_frame dut%0d cycle %0d: got cnt=%0d done=%b want %0d %b", k, c, frame_cnt[k], frame_done[k], cnt_m[k], done_m[k]);
        end
      end
    end
    idle(); step();
    $display("random traffic checked: frames %0d %0d", cnt_m[0], cnt_m[1]);
  endtask

  task automatic test_reset_mid();
    idle(); wr_rearm = 1'b1; step();
    idle(); wr_load = 1'b1; wr_addr = 17'd50; wr_valid = 1'b1; wr_data = 8'h11; step();
    wr_load = 1'b0; wr_data = 8'h22; step(); step();
    idle(); rd_req = 1'b1; rd_addr = 17'd50; step();
    rd_req = 1'b0; rd_ready = 1'b0; step();
    for (int k = 0; k < 2; k++) begin
      total++; if (rd_valid[k] !== 1'b1 || rd_data[k] !== 8'h11) begin
        bad++; $display("FAIL pre_reset_stall dut%0d: got v=%b d=%h want 1 11", k, rd_valid[k], rd_data[k]);
      end
    end
    rst = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      total++; if (rd_valid[k] !== 1'b0) begin bad++; $display("FAIL mid_reset_rd_valid dut%0d: got %b want 0", k, rd_valid[k]); end
      total++; if (wr_ptr[k] !== 17'd0) begin bad++; $display("FAIL mid_reset_ptr dut%0d: got %0d want 0", k, wr_ptr[k]); end
      total++; if (frame_cnt[k] !== 8'd0) begin bad++; $display("FAIL mid_reset_cnt dut%0d: got %0d want 0", k, frame_cnt[k]); end
    end
    idle(); step();
    $display("mid-operation reset checked");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); rst = 1'b1; wr_data = 8'h00; wr_addr = 17'd0; rd_addr = 17'd0;
    for (int k = 0; k < 2; k++) begin
      ptr_m[k] = 0; full_m[k] = 0; cnt_m[k] = 0; done_m[k] = 0;
      rv_m[k] = 0; rd_m[k] = 8'h00; rdk_m[k] = 1;
    end
    test_reset();
    test_frame_stream();
    test_oneshot();
    test_rdw();
    test_back_to_back();
    test_load();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
